// File: rtl/fp_mul_arbiter.sv
// Round-robin sequencer sharing one combinational FP multiplier among NUM_REQ requesters.
// Operands are registered into the multiplier; the product returns with its requester ID.
module fp_mul_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  output logic                  mul_valid,
  input  logic [31:0]           mul_result,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [ID_WIDTH-1:0]   rsp_id,
  input  logic                  rsp_ready,
  output logic                  busy
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e              state_q;
  logic [ID_WIDTH-1:0] ptr_q;
  logic [ID_WIDTH-1:0] grant_id_q;

  logic [ID_WIDTH-1:0] winner;
  logic                found;
  logic                grant;
  logic [31:0]         win_a;
  logic [31:0]         win_b;

  // Scan upward from the requester after the last winner, wrapping around.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    win_a  = '0;
    win_b  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_WIDTH'(idx);
        win_a  = req_a[32*idx +: 32];
        win_b  = req_b[32*idx +: 32];
      end
    end
  end

  // rst_n gates the grant so req_ready drops the moment reset asserts.
  assign grant = rst_n && (state_q == StIdle) && (!rsp_valid || rsp_ready) && found;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (32'(winner) == i);
    end
  end

  assign busy = (state_q == StIssue) || rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= ID_WIDTH'(NUM_REQ - 1);
      grant_id_q <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_valid  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (grant) begin
            mul_a      <= win_a;
            mul_b      <= win_b;
            grant_id_q <= winner;
            ptr_q      <= winner;
            mul_valid  <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          // A fresh load overrides the handshake clear above.
          rsp_data  <= mul_result;
          rsp_id    <= grant_id_q;
          rsp_valid <= 1'b1;
          mul_valid <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational single-precision FP multiplier among NUM_REQ requesters. It grants one requester at a time and registers that requester's operands into the multiplier. It captures the product into a response register and returns it with the requester ID over a valid/ready handshake. It sits between the layer compute engines and the shared multiplier instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 2, width of rsp_id; must satisfy 2**ID_WIDTH >= NUM_REQ

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_a  input  32*NUM_REQ  operand A; requester i at bits [32*i+31:32*i]
req_b  input  32*NUM_REQ  operand B, same packing as req_a
req_ready  output  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] and req_ready[i] are both high
mul_a  output  32  operand A to the shared multiplier
mul_b  output  32  operand B to the shared multiplier
mul_valid  output  1  valid to the shared multiplier
mul_result  input  32  product from the shared multiplier (combinational)
rsp_valid  output  1  response valid
rsp_data  output  32  product
rsp_id  output  ID_WIDTH  index of the requester that owns rsp_data
rsp_ready  input  1  consumer accepts the response
busy  output  1  high while in ISSUE or while rsp_valid is high

Behaviour:
- Reset (asynchronous, rst_n=0) clears all state:
  - state=IDLE, pointer=NUM_REQ-1 (requester 0 has first priority)
  - req_ready=0, mul_valid=0, mul_a=0, mul_b=0
  - rsp_valid=0, rsp_data=0, rsp_id=0, busy=0
- States: IDLE and ISSUE.
- req_ready is combinational. It is one-hot on the winner when all of the following hold; otherwise it is all zero:
  - state==IDLE
  - rsp_free = !rsp_valid || rsp_ready
  - some req_valid bit is set
- Winner: the first set req_valid bit scanning upward from pointer+1, wrapping modulo NUM_REQ.
- IDLE -> ISSUE on a grant:
  - mul_a <= req_a slice of the winner; mul_b <= req_b slice of the winner
  - grant_id <= winner; pointer <= winner; mul_valid <= 1
- ISSUE -> IDLE unconditionally after one cycle:
  - rsp_data <= mul_result, rsp_id <= grant_id, rsp_valid <= 1, mul_valid <= 0
  - mul_a and mul_b hold their values (no glitching into the multiplier)
- Response handshake:
  - rsp_valid clears on rsp_valid && rsp_ready unless a new result loads in the same edge; a new load has priority.
  - rsp_data and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- Latency: request accepted at edge N; rsp_valid is high after edge N+1. Peak throughput is one product per 2 cycles.
- Back-pressure:
  - No grant while rsp_valid=1 and rsp_ready=0; a held response is never overwritten.
  - A grant is allowed in the same cycle the held response is consumed.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Requesters must hold req_valid and operands until accepted. Dropping req_valid before acceptance is legal; that request is simply not granted.
- Single requester: back-to-back grants to the same index are allowed; the pointer wraps.
- The product is the multiplier's value, passed bit-exact (same zero, sign and normalisation rules); this block does no arithmetic.
- Reset mid-operation (ISSUE or pending response): the in-flight operation and any held response are discarded, and all outputs return to reset values immediately.

Test Plan:
- Single op, requester 1, A=0x40000000 (2.0), B=0x40400000 (3.0), rsp_ready=1 -> req_ready=4'b0010 for one cycle; two edges later rsp_valid=1, rsp_data=0x40C00000, rsp_id=1.
- All four requesters valid at once, each A=0x3FC00000 and B=0x3FC00000, rsp_ready=1 -> grants in order 0,1,2,3 every 2 cycles; each rsp_data=0x40100000 (2.25) with rsp_id 0,1,2,3.
- Back-pressure: hold rsp_ready=0 after the first response while requester 2 is valid -> no req_ready for 10 cycles and rsp_data stays stable. Raise rsp_ready -> requester 2 is granted in that same cycle.
- Sign and zero handling: requester 3 sends 0xC0000000 * 0x40400000 -> rsp_data=0xC0C00000. Requester 0 sends 0x00000000 * 0x40400000 -> rsp_data=0x00000000.
- Fairness: requester 0 valid continuously and requester 2 pulsed -> requester 2 is granted no later than the second grant after it asserts, and grants alternate 0,2.
- Reset mid-ISSUE: assert rst_n=0 in ISSUE -> rsp_valid, mul_valid and req_ready go to 0 immediately with no edge. After release, requester 0 wins first.
